// File: rtl/wide_add_pkg.sv
// Shared types and defaults for the sliced wide adder.
// Holds the sequencer state encoding and default geometry.
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_D = 16;
    localparam int SLICE_D = 4;

endpackage

// File: rtl/add_slice.sv
// Combinational W-bit ripple-carry adder slice.
// Ports: a, b, cin -> sum, cout, c_msb_in (carry into the top bit).
module add_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb_in
);

    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout     = c[W];
    assign c_msb_in = c[W-1];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder: one SLICE-bit slice reused LSB to MSB.
// Ports: clk, rst_n; in_valid/in_ready/in_a/in_b/in_cin operand side;
//   out_valid/out_ready/out_sum/out_cout/out_ovf result side; busy.
// Optional ADD_SUB_EN adds in_sub (1 = a-b, in_cin ignored).
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int SLICE = SLICE_D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef ADD_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NSLICE - 1);

    if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_geom
        $error("WIDTH must be a non-zero multiple of SLICE");
    end

    state_t state;
    state_t state_next;

    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             last;
    logic             accept;
    logic             carry_init;

    logic [SLICE-1:0] s_a;
    logic [SLICE-1:0] s_b;
    logic [SLICE-1:0] s_sum;
    logic             s_cout;
    logic             s_cmsb;

`ifdef ADD_SUB_EN
    logic sub_q;
    // Subtraction: invert b and force the initial carry to 1.
    assign s_b        = b_q[idx*SLICE +: SLICE] ^ {SLICE{sub_q}};
    assign carry_init = in_sub | in_cin;
`else
    assign s_b        = b_q[idx*SLICE +: SLICE];
    assign carry_init = in_cin;
`endif

    assign s_a    = a_q[idx*SLICE +: SLICE];
    assign last   = (idx == IDX_LAST);
    assign accept = (state == IDLE) && in_valid;

    add_slice #(
        .W (SLICE)
    ) u_slice (
        .a        (s_a),
        .b        (s_b),
        .cin      (carry_q),
        .sum      (s_sum),
        .cout     (s_cout),
        .c_msb_in (s_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef ADD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else if (accept) begin
            idx     <= '0;
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= carry_init;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef ADD_SUB_EN
            sub_q   <= in_sub;
`endif
        end else if (state == RUN) begin
            sum_q[idx*SLICE +: SLICE] <= s_sum;
            carry_q <= s_cout;
            if (last) begin
                cout_q <= s_cout;
                ovf_q  <= s_cmsb ^ s_cout;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    // Held low during reset even though the state already reads IDLE.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule
